freq_meter: RTL and testbench



---
 rtl/freq_pkg.sv | 16 +
 rtl/freq_meter_edge_sync.sv | 31 +++
 rtl/freq_meter.sv | 150 +++++++++++++++
 tb/tb_freq_meter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the reciprocal frequency meter.
//   fm_state_t  : measurement FSM encoding
//   SYNC_STAGES : metastability flops in front of the edge detector
package freq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_GATE = 3'd2,
    S_STOP = 3'd3,
    S_DONE = 3'd4
  } fm_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: multi-flop synchroniser for an asynchronous strobe plus a
// history flop for rising-edge detection.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (clears every flop)
//   din   : asynchronous input
//   level : synchronised level
//   rise  : one-cycle pulse on a synchronised 0->1 transition
module edge_sync
  import freq_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  // sq[STAGES-1:0] is the synchroniser chain, sq[STAGES] the history flop.
  logic [STAGES:0] sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sq <= '0;
    else        sq <= {sq[STAGES-1:0], din};
  end

  assign level = sq[STAGES-1];
  assign rise  = sq[STAGES-1] & ~sq[STAGES];

endmodule

// File: rtl/freq_meter.sv
// freq_meter: equal-precision (reciprocal) frequency meter.
// The gate opens on a rising edge of sig_in and closes on the first rising
// edge at or after gate_len clk cycles, so n_clk spans a whole number
// (n_sig) of input periods and f_sig = n_sig / n_clk * f_clk.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig_in     : signal under measurement (asynchronous)
//   gate_len   : minimum gate in clk cycles, sampled on accepted start
//   start      : request, accepted from IDLE only
//   busy       : measurement in progress
//   done       : one-cycle pulse, results valid from this cycle
//   n_sig      : input periods in the gate
//   n_clk      : clk cycles in the gate
//   ovf        : a counter saturated during the last measurement
//   nosig      : timed out waiting for an input edge
module freq_meter
  import freq_pkg::*;
#(
  parameter int CWID = 16,
  parameter int GWID = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig_in,
  input  logic [GWID-1:0] gate_len,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CWID-1:0] n_sig,
  output logic [GWID-1:0] n_clk,
  output logic            ovf,
  output logic            nosig
);

  fm_state_t       state, state_d;
  logic            rise, level;
  logic [GWID-1:0] glen, tmr, cc;
  logic [CWID-1:0] cs;
  logic [GWID:0]   tmr_inc;
  logic            ovf_f, nos_f;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sig_in),
    .level (level),
    .rise  (rise)
  );

  // One bit wider so the compare against glen can never wrap.
  assign tmr_inc = {1'b0, tmr} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        if (rise)                         state_d = S_GATE;
        else if (tmr_inc == {1'b0, glen}) state_d = S_DONE;
      end
      // An edge landing on the cycle the minimum gate expires is already
      // the closing edge; otherwise wait for the next one in STOP.
      S_GATE: if (tmr_inc >= {1'b0, glen}) state_d = rise ? S_DONE : S_STOP;
      S_STOP: begin
        if (rise)                         state_d = S_DONE;
        else if (tmr_inc == {1'b0, glen}) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glen  <= {{(GWID-1){1'b0}}, 1'b1};
      tmr   <= '0;
      cc    <= '0;
      cs    <= '0;
      ovf_f <= 1'b0;
      nos_f <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      n_sig <= '0;
      n_clk <= '0;
      ovf   <= 1'b0;
      nosig <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            glen  <= (gate_len == '0) ? {{(GWID-1){1'b0}}, 1'b1} : gate_len;
            busy  <= 1'b1;
            tmr   <= '0;
            cc    <= '0;
            cs    <= '0;
            ovf_f <= 1'b0;
            nos_f <= 1'b0;
            ovf   <= 1'b0;
            nosig <= 1'b0;
          end
        end
        S_ARM: begin
          if (rise) begin
            cs  <= '0;
            cc  <= '0;
            tmr <= '0;
          end else begin
            tmr <= tmr_inc[GWID-1:0];
            if (tmr_inc == {1'b0, glen}) nos_f <= 1'b1;
          end
        end
        S_GATE: begin
          if (&cc) ovf_f <= 1'b1;
          else     cc    <= cc + 1'b1;
          if (rise) begin
            if (&cs) ovf_f <= 1'b1;
            else     cs    <= cs + 1'b1;
          end
          // tmr restarts as the STOP-phase timeout counter.
          tmr <= (state_d == S_STOP) ? '0 : tmr_inc[GWID-1:0];
        end
        S_STOP: begin
          if (&cc) ovf_f <= 1'b1;
          else     cc    <= cc + 1'b1;
          if (rise) begin
            if (&cs) ovf_f <= 1'b1;
            else     cs    <= cs + 1'b1;
          end else begin
            tmr <= tmr_inc[GWID-1:0];
            if (tmr_inc == {1'b0, glen}) nos_f <= 1'b1;
          end
        end
        S_DONE: begin
          n_sig <= cs;
          n_clk <= cc;
          ovf   <= ovf_f;
          nosig <= nos_f;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in;
  logic [23:0] gate_len = '0, gate4 = '0;
  logic        start = 1'b0, start4 = 1'b0;
  logic        busy, done, ovf, nosig;
  logic [15:0] n_sig;
  logic [23:0] n_clk;
  logic        busy4, done4, ovf4, nosig4;
  logic [3:0]  n_sig4;
  logic [23:0] n_clk4;

  int errors = 0;
  int checks = 0;
  int dcount = 0;

  // stimulus generator controls
  int mode = 0;   // 0 hold low, 1 square wave, 2 p/q divider pulses
  int per  = 10;
  int dp   = 3;
  int dq   = 10;

  always #5 clk = ~clk;

  freq_meter u_dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .gate_len(gate_len),
    .start(start), .busy(busy), .done(done), .n_sig(n_sig),
    .n_clk(n_clk), .ovf(ovf), .nosig(nosig)
  );

  freq_meter #(.CWID(4), .GWID(24)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .gate_len(gate4),
    .start(start4), .busy(busy4), .done(done4), .n_sig(n_sig4),
    .n_clk(n_clk4), .ovf(ovf4), .nosig(nosig4)
  );

  initial begin
    int cnt, acc;
    cnt = 0; acc = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin cnt = (cnt + 1) % per; sig_in = (cnt < per / 2); end
        2: begin
          acc += dp;
          if (acc >= dq) begin acc -= dq; sig_in = 1'b1; end
          else sig_in = 1'b0;
        end
        default: begin sig_in = 1'b0; cnt = 0; acc = 0; end
      endcase
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (done) dcount++;
  end

  task automatic go(input int sel, input int glen);
    @(negedge clk);
    if (sel == 0) begin start = 1'b1; gate_len = glen[23:0]; end
    else begin start4 = 1'b1; gate4 = glen[23:0]; end
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc);
    logic d;
    cyc = 0;
    d = 1'b0;
    while (!d && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      d = (sel == 0) ? done : done4;
    end
    checks++;
    if (!d) begin
      errors++;
      $display("FAIL done_timeout: sel=%0d no done within %0d cycles", sel, cyc);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ovf, nosig} !== 4'b0 || n_sig !== 16'd0 || n_clk !== 24'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b nosig=%b n_sig=%0d n_clk=%0d, want all 0",
               busy, done, ovf, nosig, n_sig, n_clk);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_square;
    int cyc;
    mode = 1; per = 10;
    repeat (20) @(negedge clk);
    go(0, 100);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sq_busy: got %b want 1", busy); end
    wait_done(0, cyc);
    checks++;
    if (n_sig !== 16'd10) begin errors++; $display("FAIL sq_n_sig: got %0d want 10", n_sig); end
    checks++;
    if (n_clk !== 24'd100) begin errors++; $display("FAIL sq_n_clk: got %0d want 100", n_clk); end
    checks++;
    if (ovf !== 1'b0 || nosig !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sq_flags: ovf=%b nosig=%b busy=%b want 0 0 0", ovf, nosig, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL sq_done_pulse: done=%b one cycle later, want 0", done); end
  endtask

  task automatic test_loopback(input int p, input int q);
    int cyc, err;
    mode = 2; dp = p; dq = q;
    repeat (20) @(negedge clk);
    go(0, 1000);
    wait_done(0, cyc);
    err = int'(n_sig) * q - p * int'(n_clk);
    if (err < 0) err = -err;
    checks++;
    if (err > q || n_clk < 24'd1000) begin
      errors++;
      $display("FAIL loopback_%0d_%0d: n_sig=%0d n_clk=%0d, want ratio within 1/n_clk of %0d/%0d",
               p, q, n_sig, n_clk, p, q);
    end
    checks++;
    if (ovf !== 1'b0 || nosig !== 1'b0) begin
      errors++; $display("FAIL loopback_flags: ovf=%b nosig=%b want 0 0", ovf, nosig);
    end
  endtask

  task automatic test_nosig;
    int cyc;
    mode = 0;
    repeat (10) @(negedge clk);
    go(0, 50);
    wait_done(0, cyc);
    checks++;
    if (cyc !== 51) begin errors++; $display("FAIL nosig_latency: done after %0d cycles want 51", cyc); end
    checks++;
    if (nosig !== 1'b1 || n_sig !== 16'd0) begin
      errors++; $display("FAIL nosig_result: nosig=%b n_sig=%0d want 1 0", nosig, n_sig);
    end
  endtask

  task automatic test_saturate;
    int cyc;
    mode = 1; per = 4;
    repeat (10) @(negedge clk);
    go(1, 200);
    wait_done(1, cyc);
    checks++;
    if (n_sig4 !== 4'd15 || ovf4 !== 1'b1) begin
      errors++; $display("FAIL sat_count: n_sig=%0d ovf=%b want 15 1", n_sig4, ovf4);
    end
    checks++;
    if (n_clk4 !== 24'd200) begin errors++; $display("FAIL sat_n_clk: got %0d want 200", n_clk4); end
    go(1, 20);
    checks++;
    if (ovf4 !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear_on_start: ovf=%b want 0", ovf4); end
    wait_done(1, cyc);
    checks++;
    if (ovf4 !== 1'b0 || n_sig4 !== 4'd5 || n_clk4 !== 24'd20) begin
      errors++; $display("FAIL sat_recover: ovf=%b n_sig=%0d n_clk=%0d want 0 5 20", ovf4, n_sig4, n_clk4);
    end
  endtask

  task automatic test_back_to_back;
    int d0, cyc;
    mode = 1; per = 10;
    repeat (10) @(negedge clk);
    d0 = dcount;
    @(negedge clk);
    start = 1'b1; gate_len = 24'd100;
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_timeout: no done in %0d cycles", cyc); end
    repeat (150) @(posedge clk);
    #2;
    checks++;
    if (dcount - d0 !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d done pulses want 1", dcount - d0); end
    checks++;
    if (n_sig !== 16'd10 || n_clk !== 24'd100 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_result: n_sig=%0d n_clk=%0d busy=%b want 10 100 0", n_sig, n_clk, busy);
    end
  endtask

  task automatic test_reset_abort;
    int d0, cyc;
    mode = 1; per = 10;
    go(0, 100);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, nosig} !== 4'b0 || n_sig !== 16'd0 || n_clk !== 24'd0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b ovf=%b nosig=%b n_sig=%0d n_clk=%0d want all 0",
               busy, done, ovf, nosig, n_sig, n_clk);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = dcount;
    repeat (150) @(negedge clk);
    checks++;
    if (dcount !== d0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: pulses=%0d busy=%b want 0 0", dcount - d0, busy);
    end
    go(0, 100);
    wait_done(0, cyc);
    checks++;
    if (n_sig !== 16'd10 || n_clk !== 24'd100) begin
      errors++; $display("FAIL abort_remeasure: n_sig=%0d n_clk=%0d want 10 100", n_sig, n_clk);
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_loopback(3, 10);
    test_loopback(1, 7);
    test_nosig;
    test_saturate;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
